// File: rtl/miner_nonce_sched.sv
// Nonce sweep scheduler for the SHA-256 second-block datapath: issues padded blocks, tracks in-flight nonces, picks the first winner.
// Latency: first block issues 1 cycle after job accept; result is reported 1 cycle after the last in-flight hash returns.
// Backpressure: issue stalls while the nonce FIFO is full (a same-cycle pop frees the slot); the result is held until res_ready.
module miner_nonce_sched #(
    parameter int DEPTH    = 16,
    parameter int LEN_BITS = 640
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [95:0]  job_tail,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic [255:0] target,
    input  logic         abort,
    output logic         sha_en,
    output logic [511:0] sha_M,
    input  logic         hash_valid,
    input  logic [255:0] hash_in,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         res_found,
    output logic [31:0]  res_nonce,
    output logic         busy,
    output logic         ovf_err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_REPORT} state_t;

    state_t         state_q, state_d;
    logic [95:0]    tail_q, tail_d;
    logic [255:0]   target_q, target_d;
    logic [31:0]    cur_q, cur_d;
    logic [31:0]    end_q, end_d;
    logic           last_q, last_d;
    logic           win_vld_q, win_vld_d;
    logic [31:0]    win_nonce_q, win_nonce_d;
    logic           sha_en_q, sha_en_d;
    logic [511:0]   sha_m_q, sha_m_d;
    logic           res_found_q, res_found_d;
    logic [31:0]    res_nonce_q, res_nonce_d;
    logic           ovf_q, ovf_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    cnt_q, cnt_d;
    logic [31:0]    fifo_mem [DEPTH];

    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic match;
    logic issue;

    assign fifo_full  = (cnt_q == (AW+1)'(DEPTH));
    assign fifo_empty = (cnt_q == '0);
    // Returned hashes retire the FIFO head; an empty FIFO means a stray result.
    assign pop   = hash_valid && !fifo_empty && (state_q != S_IDLE);
    // Only the first match in issue order is kept; later ones are dropped.
    assign match = pop && (state_q == S_RUN || state_q == S_DRAIN) && !win_vld_q
                   && (hash_in < target_q);
    // A full FIFO may still accept when the head retires this same cycle.
    assign issue = (state_q == S_RUN) && (!fifo_full || pop) && !last_q
                   && !win_vld_q && !match && !abort;

    assign job_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign res_valid = (state_q == S_REPORT);
    assign res_found = res_found_q;
    assign res_nonce = res_nonce_q;
    assign sha_en    = sha_en_q;
    assign sha_M     = sha_m_q;
    assign ovf_err   = ovf_q;

    // Next-state logic: FSM transitions, issue datapath, FIFO pointers and winner tracking.
    always_comb begin
        state_d     = state_q;
        tail_d      = tail_q;
        target_d    = target_q;
        cur_d       = cur_q;
        end_d       = end_q;
        last_d      = last_q;
        win_vld_d   = win_vld_q;
        win_nonce_d = win_nonce_q;
        sha_en_d    = 1'b0;
        sha_m_d     = sha_m_q;
        res_found_d = res_found_q;
        res_nonce_d = res_nonce_q;
        ovf_d       = ovf_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;

        if (issue) begin
            sha_en_d = 1'b1;
            sha_m_d  = {tail_q, cur_q, 8'h80, 312'd0, 64'(LEN_BITS)};
            wr_ptr_d = wr_ptr_q + 1'b1;
            cur_d    = cur_q + 32'd1;
            // Flag the final nonce so an all-ones end value never wraps around.
            last_d   = (cur_q == end_q);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (issue && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!issue && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (match) begin
            win_vld_d   = 1'b1;
            win_nonce_d = fifo_mem[rd_ptr_q];
        end
        if (hash_valid && fifo_empty) begin
            ovf_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (job_valid) begin
                    tail_d      = job_tail;
                    target_d    = target;
                    cur_d       = nonce_start;
                    end_d       = nonce_end;
                    last_d      = 1'b0;
                    win_vld_d   = 1'b0;
                    win_nonce_d = '0;
                    res_found_d = 1'b0;
                    res_nonce_d = '0;
                    state_d     = (nonce_start > nonce_end) ? S_REPORT : S_RUN;
                end
            end
            S_RUN: begin
                if (win_vld_d || abort || last_d) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cnt_d == '0) begin
                    state_d     = S_REPORT;
                    res_found_d = win_vld_d;
                    res_nonce_d = win_vld_d ? win_nonce_d : 32'd0;
                end
            end
            S_REPORT: begin
                if (res_ready) begin
                    state_d     = S_IDLE;
                    res_found_d = 1'b0;
                    res_nonce_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            tail_q      <= '0;
            target_q    <= '0;
            cur_q       <= '0;
            end_q       <= '0;
            last_q      <= 1'b0;
            win_vld_q   <= 1'b0;
            win_nonce_q <= '0;
            sha_en_q    <= 1'b0;
            sha_m_q     <= '0;
            res_found_q <= 1'b0;
            res_nonce_q <= '0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            tail_q      <= tail_d;
            target_q    <= target_d;
            cur_q       <= cur_d;
            end_q       <= end_d;
            last_q      <= last_d;
            win_vld_q   <= win_vld_d;
            win_nonce_q <= win_nonce_d;
            sha_en_q    <= sha_en_d;
            sha_m_q     <= sha_m_d;
            res_found_q <= res_found_d;
            res_nonce_q <= res_nonce_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    // In-flight nonce storage; contents need no reset since the pointers gate every read.
    always_ff @(posedge clk) begin
        if (issue) begin
            fifo_mem[wr_ptr_q] <= cur_q;
        end
    end
endmodule

// File: tb/tb_miner_nonce_sched.sv
module tb_miner_nonce_sched;
    localparam int DEPTH = 16;

    logic         clk;
    logic         reset;
    logic         job_valid;
    logic         job_ready;
    logic [95:0]  job_tail;
    logic [31:0]  nonce_start;
    logic [31:0]  nonce_end;
    logic [255:0] target;
    logic         abort;
    logic         sha_en;
    logic [511:0] sha_M;
    logic         hash_valid;
    logic [255:0] hash_in;
    logic         res_valid;
    logic         res_ready;
    logic         res_found;
    logic [31:0]  res_nonce;
    logic         busy;
    logic         ovf_err;

    miner_nonce_sched #(.DEPTH(DEPTH), .LEN_BITS(640)) dut (
        .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
        .job_tail(job_tail), .nonce_start(nonce_start), .nonce_end(nonce_end),
        .target(target), .abort(abort), .sha_en(sha_en), .sha_M(sha_M),
        .hash_valid(hash_valid), .hash_in(hash_in), .res_valid(res_valid),
        .res_ready(res_ready), .res_found(res_found), .res_nonce(res_nonce),
        .busy(busy), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;
    int cyc;

    // Datapath / reference model state
    bit           dp_on;
    int           lat;
    bit           has_win;
    logic [31:0]  win_n;
    logic [31:0]  dp_nonce[$];
    int           dp_due[$];
    logic [31:0]  exp_nonce;
    int           issued;
    longint       total;
    int           late_issues;
    bit           win_drv;
    bit           refill_en;
    bit           refill_pend;
    bit           first_ret_chk;
    bit           exp_ovf;
    logic [511:0] last_M;
    logic [95:0]  cur_tail;
    logic [255:0] cur_target;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // A hash strictly below target for the chosen winner, target or above otherwise.
    function automatic logic [255:0] hash_of(input logic [31:0] n);
        if (has_win && n == win_n)
            return cur_target - 256'($urandom_range(1, 1000));
        return cur_target + 256'($urandom_range(0, 3));
    endfunction

    // One clock: observe the DUT after the edge, then drive the datapath for the next edge.
    task automatic tick();
        logic [511:0] exp_m;
        logic [31:0]  n;
        @(negedge clk);
        cyc++;
        if (refill_pend) begin
            chk("refill_issue", sha_en, 1'b1);
            refill_pend = 0;
        end
        if (sha_en === 1'b1) begin
            exp_m = {cur_tail, exp_nonce, 8'h80, 312'd0, 64'd640};
            chk("sha_M", sha_M, exp_m);
            if (win_drv) late_issues++;
            dp_nonce.push_back(exp_nonce);
            dp_due.push_back(cyc + lat);
            issued++;
            exp_nonce = exp_nonce + 32'd1;
            last_M = exp_m;
            chk("in_flight_le_depth", dp_nonce.size() <= DEPTH, 1'b1);
        end else begin
            chk("sha_M_hold", sha_M, last_M);
        end
        if (dp_on) begin
            if (dp_due.size() > 0 && dp_due[0] <= cyc) begin
                n = dp_nonce.pop_front();
                void'(dp_due.pop_front());
                hash_valid = 1'b1;
                hash_in = hash_of(n);
                if (has_win && n == win_n) win_drv = 1;
                if (first_ret_chk) begin
                    chk("issued_before_first_ret", issued, DEPTH);
                    first_ret_chk = 0;
                end
                if (refill_en && issued < total) refill_pend = 1;
            end else begin
                hash_valid = 1'b0;
                hash_in = '0;
            end
        end
    endtask

    task automatic start_job(input logic [31:0] s, input logic [31:0] e, input int l,
                             input bit w, input logic [31:0] wn, input bit refill);
        job_tail = {$urandom(), $urandom(), $urandom()};
        target = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
        target[255] = 1'b0;
        target[254] = 1'b1;
        cur_tail = job_tail;
        cur_target = target;
        lat = l; has_win = w; win_n = wn; exp_nonce = s;
        issued = 0; late_issues = 0; win_drv = 0;
        refill_en = refill; refill_pend = 0; first_ret_chk = refill;
        total = (s > e) ? 0 : (longint'(e) - longint'(s) + 1);
        nonce_start = s; nonce_end = e; dp_on = 1;
        chk("job_ready_idle", job_ready, 1'b1);
        job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
        chk("busy_after_accept", busy, 1'b1);
    endtask

    task automatic run_job(input logic [31:0] s, input logic [31:0] e, input int l,
                           input bit w, input logic [31:0] wn, input int ab_after, input bit refill);
        int budget;
        bit aborted;
        bit exp_found;
        logic [31:0] exp_res;
        start_job(s, e, l, w, wn, refill);
        if (ab_after > 0 && ab_after < total) total = ab_after;
        budget = 0;
        aborted = 0;
        while (res_valid !== 1'b1 && budget < 4000) begin
            if (ab_after > 0 && issued == ab_after && !aborted) begin
                abort = 1'b1;
                aborted = 1;
            end else begin
                abort = 1'b0;
            end
            tick();
            budget++;
        end
        abort = 1'b0;
        if (budget >= 4000) begin
            chk("res_timeout", 1'b0, 1'b1);
            return;
        end
        exp_found = w && (s <= e) && (s <= wn) && (wn <= e);
        exp_res = exp_found ? wn : 32'd0;
        chk("res_found", res_found, exp_found);
        chk("res_nonce", res_nonce, exp_res);
        if (!w) begin
            chk("issue_count", issued, total);
        end else begin
            chk("issued_through_winner", issued >= (wn - s + 1), 1'b1);
            chk("no_issue_after_win", late_issues, 0);
        end
        chk("drained", dp_nonce.size(), 0);
        chk("ovf_err", ovf_err, exp_ovf);
        chk("job_ready_in_report", job_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("res_hold_valid", res_valid, 1'b1);
            chk("res_hold_found", res_found, exp_found);
            chk("res_hold_nonce", res_nonce, exp_res);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("res_valid_clear", res_valid, 1'b0);
        chk("job_ready_after", job_ready, 1'b1);
        chk("busy_idle", busy, 1'b0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] s;
        logic [31:0] e;
        int len;
        bit w;
        clk = 0; reset = 0; job_valid = 0; job_tail = '0; nonce_start = '0; nonce_end = '0;
        target = '0; abort = 0; hash_valid = 0; hash_in = '0; res_ready = 0;
        n_cmp = 0; n_bad = 0; cyc = 0; dp_on = 0; lat = 1; has_win = 0; win_n = '0;
        exp_nonce = '0; issued = 0; total = 0; late_issues = 0; win_drv = 0;
        refill_en = 0; refill_pend = 0; first_ret_chk = 0; exp_ovf = 0; last_M = '0;
        cur_tail = '0; cur_target = '0;

        repeat (3) tick();
        reset = 1;
        tick();
        chk("rst_job_ready", job_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_found", res_found, 1'b0);
        chk("rst_res_nonce", res_nonce, 32'd0);
        chk("rst_sha_en", sha_en, 1'b0);
        chk("rst_sha_M", sha_M, 512'd0);
        chk("rst_ovf", ovf_err, 1'b0);

        run_job(32'd5, 32'd8, 3, 0, 32'd0, 0, 0);
        run_job(32'd0, 32'd99, 3, 1, 32'd42, 0, 0);
        run_job(32'd0, 32'd39, 40, 0, 32'd0, 0, 1);
        run_job(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 0, 32'd0, 0, 0);
        run_job(32'd10, 32'd9, 3, 0, 32'd0, 0, 0);
        run_job(32'd100, 32'd199, 3, 0, 32'd0, 3, 0);
        run_job(32'hFFFF_FFFC, 32'hFFFF_FFFF, 2, 1, 32'hFFFF_FFFF, 0, 0);

        for (int k = 0; k < 8; k++) begin
            s = 32'($urandom_range(0, 100000));
            len = $urandom_range(0, 30);
            e = ($urandom_range(0, 5) == 0) ? s - 32'd1 : s + 32'(len);
            w = $urandom_range(0, 1) == 1;
            run_job(s, e, $urandom_range(1, 25), w, s + 32'($urandom_range(0, len)), 0, 0);
        end

        // Reset in the middle of a job, then stray results with nothing in flight.
        start_job(32'd0, 32'd99, 5, 0, 32'd0, 0);
        repeat (12) tick();
        dp_on = 0;
        hash_valid = 1'b0;
        last_M = '0;
        reset = 0;
        tick();
        reset = 1;
        dp_nonce.delete();
        dp_due.delete();
        chk("mid_rst_sha_en", sha_en, 1'b0);
        chk("mid_rst_sha_M", sha_M, 512'd0);
        chk("mid_rst_res_valid", res_valid, 1'b0);
        chk("mid_rst_res_found", res_found, 1'b0);
        chk("mid_rst_res_nonce", res_nonce, 32'd0);
        chk("mid_rst_ovf", ovf_err, 1'b0);
        chk("mid_rst_job_ready", job_ready, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        tick();
        chk("post_rst_no_issue", sha_en, 1'b0);
        hash_valid = 1'b1;
        hash_in = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
        tick();
        hash_valid = 1'b0;
        exp_ovf = 1;
        chk("ovf_set", ovf_err, 1'b1);
        hash_valid = 1'b1;
        tick();
        hash_valid = 1'b0;
        tick();
        chk("ovf_sticky", ovf_err, 1'b1);
        chk("ovf_job_ready", job_ready, 1'b1);
        run_job(32'd200, 32'd207, 4, 1, 32'd203, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/miner_nonce_sched.md
Name: miner_nonce_sched

Overview:
- Sequences the SHA-256 second-block datapath (message schedule, rounds, compare) for the bitcoin miner.
- Accepts a mining job and sweeps a nonce range. Issues one padded 512-bit block per accepted slot with an enable pulse.
- Tracks in-flight nonces, matches returned hashes against the target, and reports the first winning nonce or range exhaustion.

Parameters:
- DEPTH, 16, maximum in-flight blocks (nonce FIFO depth, power of 2).
- LEN_BITS, 640, message length field placed in M[63:0] (80-byte header).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-low.
- job_valid  in  1  job offered.
- job_ready  out  1  high only in IDLE.
- job_tail  in  96  header bytes 64..75, latched on accept.
- nonce_start  in  32  first nonce, inclusive.
- nonce_end  in  32  last nonce, inclusive.
- target  in  256  hash must be strictly less than target (unsigned); latched on accept.
- abort  in  1  cancel current job.
- sha_en  out  1  one-cycle issue pulse to datapath.
- sha_M  out  512  block presented with sha_en.
- hash_valid  in  1  result from datapath, in issue order.
- hash_in  in  256  result hash.
- res_valid  out  1  result pending.
- res_ready  in  1  result consumed.
- res_found  out  1  1 = winner, 0 = range exhausted or aborted.
- res_nonce  out  32  winning nonce; 0 when res_found=0.
- busy  out  1  state != IDLE.
- ovf_err  out  1  sticky: hash_valid arrived with FIFO empty.

Behaviour:
- Reset (reset=0 at posedge): state IDLE. sha_en=0, sha_M=0, res_valid=0, res_found=0, res_nonce=0, ovf_err=0, FIFO empty, job_ready=1. Applies mid-job; in-flight results are then ignored.
- States: IDLE, RUN, DRAIN, REPORT.
- IDLE, job_valid & job_ready: latch job_tail, target, nonce_start (into cur_nonce), nonce_end.
  - nonce_start > nonce_end -> REPORT with res_found=0.
  - Otherwise -> RUN.
- RUN, issue when FIFO not full and no stop condition:
  - Drive sha_en=1 for one cycle with sha_M registered.
  - sha_M layout: [511:416]=job_tail, [415:384]=cur_nonce, [383:376]=8'h80, [375:64]=0, [63:0]=LEN_BITS.
  - Push cur_nonce into FIFO; cur_nonce+1.
  - Issue rate: at most 1 block per cycle.
- Last issue is when cur_nonce==nonce_end. Use a last_issued flag so nonce_end=32'hFFFFFFFF terminates and never wraps.
- hash_valid in any non-IDLE state: pop FIFO head.
  - Compare only in RUN/DRAIN while no winner is latched.
  - hash_in < target -> latch popped nonce as winner.
- Simultaneous push and pop in the same cycle: occupancy unchanged; legal when full.
- RUN -> DRAIN when a winner is latched, abort=1, or last_issued. No further issues after that.
- DRAIN: wait until FIFO empty, including the pop happening this cycle, then -> REPORT.
  - res_found=1 if a winner is latched; res_nonce=winner.
  - Otherwise res_found=0.
  - Later matches in DRAIN are discarded; the first match by issue order wins.
- REPORT: res_valid=1 and outputs held stable until res_ready=1. Then res_valid=0 -> IDLE.
- abort in IDLE or REPORT: ignored.
- hash_valid with FIFO empty (any state): ovf_err=1 until reset; the FIFO is not modified.
- sha_M holds its last value when sha_en=0.

Test Plan:
- Range 5..8, datapath model with latency 3, no hash below target:
  - 4 sha_en pulses on consecutive cycles with nonces 5, 6, 7, 8 in M[415:384].
  - M[383:376]=8'h80, M[63:0]=640.
  - Then res_valid with res_found=0.
- Range 0..99, target met only for nonce 42:
  - Issue stops after the first match is seen.
  - Everything already issued drains.
  - res_found=1, res_nonce=42.
  - res_valid stays high across 3 cycles with res_ready=0.
- DEPTH=16, datapath latency 40:
  - Exactly 16 issues occur, then sha_en stays low until the first hash_valid.
  - After that, 1 issue per returned hash.
- nonce_start=nonce_end=32'hFFFFFFFF -> exactly one issue, no wrap, then res_found=0. Separately, nonce_start=10, nonce_end=9 -> no issue, immediate res_found=0.
- abort after the 3rd issue:
  - No 4th issue.
  - 3 results drain, then res_found=0.
  - job_ready=1 after res_ready.
- Mid-RUN reset=0 for one cycle, then stray hash_valid pulses:
  - All outputs return to their reset values.
  - ovf_err=1 after the first stray hash_valid.
  - A new job is accepted normally.
